// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// Optional WAIT-state abort is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [DATA_W-1:0]           uart_tx_data,
  output logic                        uart_tx_send,
  input  logic                        uart_tx_flag,
  output logic                        uart_tx_clr,
  output logic                        busy,
  output logic [ID_W-1:0]             grant_id,
  output logic                        timeout_err,
  input  logic                        err_clr,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_last;
  logic [ID_W-1:0]     r_grant;
  logic [DATA_W-1:0]   r_data;
  logic [ID_W-1:0]     w_win;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_any;
  logic                w_accept;
  logic                w_timeout;

  // Search order starts one past the last winner; lower k is written last so it wins.
  always_comb begin
    w_any      = 1'b0;
    w_win      = r_last;
    w_win_data = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(r_last) + k) % NUM_REQ && req_valid[i]) begin
          w_any = 1'b1;
          w_win = ID_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_win) w_win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Handshake: a byte transfers on the rising edge where req_valid[i] & req_ready[i];
  // ready is offered only in IDLE with no stale flag, one-hot on the round-robin winner.
  assign w_accept = (r_state == S_IDLE) && !uart_tx_flag && w_any;

  always_comb begin
    w_next       = r_state;
    req_ready    = '0;
    req_done     = '0;
    uart_tx_send = 1'b0;
    uart_tx_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (uart_tx_flag) begin
          uart_tx_clr = 1'b1;
        end else if (w_any) begin
          for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (ID_W'(i) == w_win);
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        uart_tx_send = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        if (uart_tx_flag || w_timeout) w_next = S_CLR;
      end
      S_CLR: begin
        uart_tx_clr = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_done[i] = (ID_W'(i) == r_grant);
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Keeps the IDLE-decoded outputs quiet while reset is held.
    if (rst) begin
      req_ready   = '0;
      uart_tx_clr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= ID_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last  <= w_win;
        r_grant <= w_win;
        r_data  <= w_win_data;
      end
    end
  end

  assign uart_tx_data = r_data;
  assign grant_id     = r_grant;
  assign busy         = (r_state != S_IDLE);
  assign dbg_state    = r_state;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  assign w_timeout = (r_state == S_WAIT) && !uart_tx_flag &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_SEND) r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      // A same-cycle abort takes priority over the software clear.
      if (w_timeout) r_timeout_err <= 1'b1;
      else if (err_clr) r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign w_timeout        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester driver, UART frame model, scoreboard monitor, directed tests.
// Define UART_ARB_TIMEOUT_EN for both files to include the abort test.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 1;
  localparam int TMO     = 16;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         uart_tx_data;
  logic                      uart_tx_send;
  logic                      uart_tx_flag;
  logic                      uart_tx_clr;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      timeout_err;
  logic                      err_clr;
  logic [1:0]                dbg_state;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .uart_tx_data(uart_tx_data),
    .uart_tx_send(uart_tx_send), .uart_tx_flag(uart_tx_flag), .uart_tx_clr(uart_tx_clr),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [ID_W+DATA_W-1:0] exp_q[$];
  logic [ID_W-1:0]        pend_q[$];
  int                     rem[NUM_REQ];
  int                     frame_len = 20;
  int                     frame_cnt = 0;
  logic [NUM_REQ-1:0]     drv_hs;
  logic                   m_send, m_clr, prev_send;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input int i, input int n, input logic [DATA_W-1:0] d);
    rem[i]                      = n;
    req_data[i*DATA_W +: DATA_W] = d;
    req_valid[i]                = (n > 0);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (!busy && exp_q.size() == 0 && pend_q.size() == 0 && req_valid == '0) break;
    end
    check(name, (i < max_cyc), 1);
  endtask

  task automatic wait_send(input string name, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (uart_tx_send) break;
    end
    check(name, (i < max_cyc), 1);
  endtask

  // requester driver: drops valid and scrambles data once its bytes are accepted
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk); #2;
      drv_hs = req_valid & req_ready;
      @(posedge clk);
      if (rst) drv_hs = '0;
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drv_hs[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin
            req_valid[i]                = 1'b0;
            req_data[i*DATA_W +: DATA_W] = 8'hEE;
          end
        end
      end
    end
  end

  // UART model: flag rises frame_len cycles after send, cleared by clr
  initial begin
    uart_tx_flag = 1'b0;
    forever begin
      @(negedge clk); #2;
      m_send = uart_tx_send;
      m_clr  = uart_tx_clr;
      @(posedge clk); #1;
      if (m_clr) uart_tx_flag = 1'b0;
      if (m_send && frame_len > 0) frame_cnt = frame_len;
      else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) uart_tx_flag = 1'b1;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [ID_W+DATA_W-1:0] e;
    logic [ID_W-1:0]        id;
    prev_send = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (!rst) begin
        if (uart_tx_send) begin
          check("sb_send_width", prev_send, 0);
          if (exp_q.size() == 0) begin
            check("sb_unexpected_send", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_send", {grant_id, uart_tx_data}, e);
            pend_q.push_back(e[ID_W+DATA_W-1 -: ID_W]);
          end
        end
        if (req_done != '0) begin
          if (pend_q.size() == 0) begin
            check("sb_unexpected_done", req_done, 0);
          end else begin
            id = pend_q.pop_front();
            check("sb_done", req_done, 32'(2'b01 << id));
          end
        end
      end
      prev_send = uart_tx_send;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    err_clr = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_send", uart_tx_send, 0);
    check("rst_clr", uart_tx_clr, 0);
    check("rst_ready", req_ready, 0);
    check("rst_done", req_done, 0);
    check("rst_data", uart_tx_data, 0);
    check("rst_grant", grant_id, 0);
    check("rst_state", dbg_state, 0);
    check("rst_terr", timeout_err, 0);

    // single byte from req0, ready same cycle, send one cycle later
    @(negedge clk);
    rst = 1'b0;
    push_req(0, 1, 8'h41);
    exp_q.push_back({1'b0, 8'h41});
    #1;
    check("t1_ready", req_ready, 2'b01);
    @(negedge clk); #1;
    check("t1_send", uart_tx_send, 1);
    check("t1_data", uart_tx_data, 8'h41);
    @(negedge clk); #1;
    check("t1_send_low", uart_tx_send, 0);
    check("t1_busy", busy, 1);
    wait_idle("t1_idle", 100);

    // flag -> clr/done exactly one cycle later, busy drops after
    @(negedge clk);
    push_req(1, 1, 8'h5A);
    exp_q.push_back({1'b1, 8'h5A});
    begin
      int i;
      for (i = 0; i < 60; i++) begin
        @(negedge clk); #1;
        if (uart_tx_flag) break;
      end
      check("t3_flag_seen", (i < 60), 1);
    end
    check("t3_clr_pre", uart_tx_clr, 0);
    check("t3_done_pre", req_done, 0);
    @(negedge clk); #1;
    check("t3_clr", uart_tx_clr, 1);
    check("t3_done", req_done, 2'b10);
    @(negedge clk); #1;
    check("t3_clr_post", uart_tx_clr, 0);
    check("t3_done_post", req_done, 0);
    check("t3_busy_post", busy, 0);
    wait_idle("t3_idle", 100);

    // both requesters hold valid: grants alternate 0,1,0,1
    @(negedge clk);
    push_req(0, 2, 8'h55);
    push_req(1, 2, 8'hAA);
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b1, 8'hAA});
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b1, 8'hAA});
    wait_idle("t2_idle", 400);

    // reset during WAIT: outputs drop at once, req0 wins afterwards
    @(negedge clk);
    push_req(0, 1, 8'h33);
    exp_q.push_back({1'b0, 8'h33});
    wait_send("t5_send", 50);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_data", uart_tx_data, 0);
    check("t5_state", dbg_state, 0);
    check("t5_clr", uart_tx_clr, 0);
    pend_q.delete();
    frame_cnt    = 0;
    uart_tx_flag = 1'b0;
    push_req(0, 1, 8'h11);
    push_req(1, 1, 8'h22);
    check("t5_ready_in_rst", req_ready, 0);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_rr_after_rst", req_ready, 2'b01);
    wait_idle("t5_idle", 200);

    // stale flag at reset release: clr first, grant one cycle later
    @(negedge clk);
    rst          = 1'b1;
    uart_tx_flag = 1'b1;
    push_req(0, 1, 8'h3C);
    exp_q.push_back({1'b0, 8'h3C});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4_clr", uart_tx_clr, 1);
    check("t4_ready_blocked", req_ready, 0);
    @(negedge clk); #1;
    check("t4_clr_low", uart_tx_clr, 0);
    check("t4_ready", req_ready, 2'b01);
    wait_idle("t4_idle", 100);

`ifdef UART_ARB_TIMEOUT_EN
    // flag never rises: abort 16 cycles into WAIT, sticky error until err_clr
    @(negedge clk);
    frame_len = 0;
    push_req(0, 1, 8'h77);
    exp_q.push_back({1'b0, 8'h77});
    wait_send("t6_send", 50);
    repeat (16) @(negedge clk);
    #1;
    check("t6_clr_early", uart_tx_clr, 0);
    check("t6_busy", busy, 1);
    check("t6_terr_early", timeout_err, 0);
    @(negedge clk); #1;
    check("t6_clr", uart_tx_clr, 1);
    check("t6_done", req_done, 2'b01);
    check("t6_terr", timeout_err, 1);
    @(negedge clk); #1;
    check("t6_terr_sticky", timeout_err, 1);
    check("t6_busy_post", busy, 0);
    err_clr = 1'b1;
    @(negedge clk); #1;
    err_clr = 1'b0;
    check("t6_terr_clr", timeout_err, 0);
    frame_len = 20;
`else
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk); #1;
    err_clr = 1'b0;
    check("terr_tied", timeout_err, 0);
`endif

    repeat (3) @(negedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_pend_q_empty", pend_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
